// File: rtl/uart_rx_fifo.sv
// UART receiver with mid-bit sampling, parity/stop checking
// and a show-ahead receive FIFO with sticky error flags.
module uart_rx_fifo #(
  parameter int CLKS_PER_BIT = 217,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               rxd,
  input  logic                               rd_en,
  output logic [DATA_BITS-1:0]               rd_data,
  output logic                               rd_valid,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]    count,
  input  logic                               clr_err,
  output logic                               overflow,
  output logic                               frame_err,
  output logic                               parity_err
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int NW = $clog2(FIFO_DEPTH+1);
  localparam int BW = $clog2(DATA_BITS+1);
  localparam logic [CW-1:0] CNT_FULL = CW'(CLKS_PER_BIT-1);
  localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT/2-1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS-1);
  localparam logic [NW-1:0] FULL_CNT = NW'(FIFO_DEPTH);
  localparam logic LAST_STOP = (STOP_BITS == 2);
  localparam logic ODD_PAR = (PARITY == 1);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK
  } state_t;

  state_t               state_q, state_d;
  logic                 meta_q, meta_d;
  logic                 rxs_q, rxs_d;
  logic                 prev_q, prev_d;
  logic                 fall_q, fall_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [BW-1:0]        bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 bad_par_q, bad_par_d;
  logic                 stop_q, stop_d;
  logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [NW-1:0]        count_q, count_d;
  logic                 ov_q, ov_d;
  logic                 fe_q, fe_d;
  logic                 pe_q, pe_d;
  logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];

  logic tick, push, set_fe, set_pe;
  logic do_push, do_pop, set_ov;

  always_comb begin
    meta_d    = rxd;
    rxs_d     = meta_q;
    prev_d    = rxs_q;
    fall_d    = prev_q & ~rxs_q;
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_d     = bit_q;
    shift_d   = shift_q;
    bad_par_d = bad_par_q;
    stop_d    = stop_q;
    push      = 1'b0;
    set_fe    = 1'b0;
    set_pe    = 1'b0;
    tick      = (cnt_q == '0);
    if (state_q != S_IDLE && state_q != S_BREAK)
      cnt_d = tick ? CNT_FULL : cnt_q - 1'b1;
    unique case (state_q)
      S_IDLE: begin
        if (fall_q) begin
          state_d = S_START;
          cnt_d   = CNT_HALF;
        end
      end
      S_START: begin
        if (tick) begin
          if (rxs_q) begin
            state_d = S_IDLE;
          end else begin
            state_d   = S_DATA;
            bit_d     = '0;
            bad_par_d = 1'b0;
            stop_d    = 1'b0;
          end
        end
      end
      S_DATA: begin
        if (tick) begin
          shift_d = {rxs_q, shift_q[DATA_BITS-1:1]};
          bit_d   = bit_q + 1'b1;
          if (bit_q == LAST_BIT)
            state_d = (PARITY != 0) ? S_PARITY : S_STOP;
        end
      end
      S_PARITY: begin
        if (tick) begin
          bad_par_d = rxs_q != (^shift_q ^ ODD_PAR);
          state_d   = S_STOP;
        end
      end
      S_STOP: begin
        if (tick) begin
          stop_d = 1'b1;
          if (!rxs_q) begin
            set_fe  = 1'b1;
            state_d = S_BREAK;
          end else if (stop_q == LAST_STOP) begin
            set_pe  = bad_par_q;
            push    = ~bad_par_q;
            state_d = S_IDLE;
          end
        end
      end
      S_BREAK: begin
        if (rxs_q) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // A full FIFO still accepts a byte when a pop frees a slot
  always_comb begin
    do_pop   = rd_en && (count_q != '0);
    do_push  = push && (count_q != FULL_CNT || do_pop);
    set_ov   = push && !do_push;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    if (do_push && !do_pop) count_d = count_q + 1'b1;
    if (!do_push && do_pop) count_d = count_q - 1'b1;
    ov_d = (ov_q & ~clr_err) | set_ov;
    fe_d = (fe_q & ~clr_err) | set_fe;
    pe_d = (pe_q & ~clr_err) | set_pe;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q    <= 1'b1;
      rxs_q     <= 1'b1;
      prev_q    <= 1'b1;
      fall_q    <= 1'b0;
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      bad_par_q <= 1'b0;
      stop_q    <= 1'b0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      ov_q      <= 1'b0;
      fe_q      <= 1'b0;
      pe_q      <= 1'b0;
    end else begin
      meta_q    <= meta_d;
      rxs_q     <= rxs_d;
      prev_q    <= prev_d;
      fall_q    <= fall_d;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      bad_par_q <= bad_par_d;
      stop_q    <= stop_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      ov_q      <= ov_d;
      fe_q      <= fe_d;
      pe_q      <= pe_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= shift_q;
  end

  assign rd_valid   = (count_q != '0);
  assign rd_data    = rd_valid ? mem_q[rd_ptr_q] : '0;
  assign count      = count_q;
  assign overflow   = ov_q;
  assign frame_err  = fe_q;
  assign parity_err = pe_q;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench: instance a uses defaults (217 clk/bit, 8N1),
// instance b uses 16 clk/bit with even parity.
module tb_uart_rx_fifo;
  localparam int CA = 217;
  localparam int CB = 16;
  localparam int LA = 3 + CA/2 + 9*CA + 1;
  localparam int LB = 3 + CB/2 + 10*CB + 1;

  logic clk = 1'b0;
  always #20 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic       rst_a, rxd_a, rd_en_a, clr_a;
  logic [7:0] data_a;
  logic       valid_a, ov_a, fe_a, pe_a;
  logic [4:0] count_a;
  logic       rst_b, rxd_b, rd_en_b, clr_b;
  logic [7:0] data_b;
  logic       valid_b, ov_b, fe_b, pe_b;
  logic [4:0] count_b;

  uart_rx_fifo u_a (
    .clk(clk), .rst(rst_a), .rxd(rxd_a), .rd_en(rd_en_a),
    .rd_data(data_a), .rd_valid(valid_a), .count(count_a),
    .clr_err(clr_a), .overflow(ov_a), .frame_err(fe_a),
    .parity_err(pe_a)
  );

  uart_rx_fifo #(
    .CLKS_PER_BIT(CB), .DATA_BITS(8), .PARITY(2),
    .STOP_BITS(1), .FIFO_DEPTH(16)
  ) u_b (
    .clk(clk), .rst(rst_b), .rxd(rxd_b), .rd_en(rd_en_b),
    .rd_data(data_b), .rd_valid(valid_b), .count(count_b),
    .clr_err(clr_b), .overflow(ov_b), .frame_err(fe_b),
    .parity_err(pe_b)
  );

  int n_chk = 0;
  int n_err = 0;
  int t0;
  logic [7:0] exp_q [$];

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic sync();
    @(posedge clk); #1;
  endtask

  task automatic hold_bit(input bit b, input logic v);
    if (b) rxd_b = v; else rxd_a = v;
    repeat (b ? CB : CA) @(posedge clk);
    #1;
  endtask

  // b always carries an even parity bit, optionally inverted
  task automatic send(input bit b, input logic [7:0] d,
                      input bit pflip, input logic stop_v);
    hold_bit(b, 1'b0);
    for (int i = 0; i < 8; i++) hold_bit(b, d[i]);
    if (b) hold_bit(b, (^d) ^ pflip);
    hold_bit(b, stop_v);
  endtask

  task automatic pop(input bit b);
    sync();
    if (b) rd_en_b = 1'b1; else rd_en_a = 1'b1;
    sync();
    rd_en_a = 1'b0;
    rd_en_b = 1'b0;
  endtask

  task automatic pulse_clr(input bit b);
    sync();
    if (b) clr_b = 1'b1; else clr_a = 1'b1;
    sync();
    clr_a = 1'b0;
    clr_b = 1'b0;
  endtask

  initial begin
    rxd_a = 1'b1; rd_en_a = 1'b0; clr_a = 1'b0; rst_a = 1'b1;
    rxd_b = 1'b1; rd_en_b = 1'b0; clr_b = 1'b0; rst_b = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", valid_a, 0);
    chk("rst_count", count_a, 0);
    chk("rst_data", data_a, 0);
    chk("rst_flags", {ov_a, fe_a, pe_a}, 0);
    sync();
    rst_a = 1'b0;
    rst_b = 1'b0;
    sync();

    // single byte with exact latency
    t0 = cyc;
    fork
      send(0, 8'h4F, 0, 1'b1);
      begin
        while (cyc < t0 + LA - 1) @(negedge clk);
        chk("t1_early", valid_a, 0);
        @(negedge clk);
        chk("t1_valid", valid_a, 1);
        chk("t1_data", data_a, 8'h4F);
        chk("t1_count", count_a, 1);
      end
    join
    pop(0);
    @(negedge clk);
    chk("t1_popv", valid_a, 0);
    chk("t1_popc", count_a, 0);
    chk("t1_flags", {ov_a, fe_a, pe_a}, 0);

    // back-to-back frames
    sync();
    send(0, 8'h4F, 0, 1'b1);
    send(0, 8'h4B, 0, 1'b1);
    send(0, 8'h0A, 0, 1'b1);
    @(negedge clk);
    chk("t2_count", count_a, 3);
    exp_q = '{8'h4F, 8'h4B, 8'h0A};
    foreach (exp_q[i]) begin
      @(negedge clk);
      chk("t2_data", data_a, exp_q[i]);
      pop(0);
    end
    @(negedge clk);
    chk("t2_empty", count_a, 0);

    // parity error, clear, then good byte
    sync();
    send(1, 8'h41, 1, 1'b1);
    @(negedge clk);
    chk("t3_pe", pe_b, 1);
    chk("t3_count", count_b, 0);
    pulse_clr(1);
    @(negedge clk);
    chk("t3_clr", pe_b, 0);
    sync();
    send(1, 8'h41, 0, 1'b1);
    @(negedge clk);
    chk("t3_count2", count_b, 1);
    chk("t3_data", data_b, 8'h41);
    chk("t3_pe2", pe_b, 0);
    pop(1);

    // framing error followed by a held-low line
    sync();
    send(0, 8'h55, 0, 1'b0);
    @(negedge clk);
    chk("t4_fe", fe_a, 1);
    chk("t4_count", count_a, 0);
    pulse_clr(0);
    repeat (3*CA) @(posedge clk);
    @(negedge clk);
    chk("t4_nofe", fe_a, 0);
    chk("t4_count2", count_a, 0);
    sync();
    rxd_a = 1'b1;
    repeat (CA) @(posedge clk);
    #1;
    send(0, 8'hA5, 0, 1'b1);
    @(negedge clk);
    chk("t4_data", data_a, 8'hA5);
    chk("t4_count3", count_a, 1);
    chk("t4_fe2", fe_a, 0);

    // overflow: 17 bytes into 16 entries
    sync();
    for (int i = 0; i < 17; i++) send(1, 8'(i), 0, 1'b1);
    @(negedge clk);
    chk("t5_count", count_b, 16);
    chk("t5_ov", ov_b, 1);
    chk("t5_head", data_b, 8'h00);
    sync();
    rst_b = 1'b1;
    sync();
    rst_b = 1'b0;
    @(negedge clk);
    chk("t5_rst", {count_b, ov_b}, 0);
    sync();
    for (int i = 0; i < 16; i++) send(1, 8'(i), 0, 1'b1);
    t0 = cyc;
    fork
      send(1, 8'h10, 0, 1'b1);
      begin
        while (cyc < t0 + LB - 1) @(negedge clk);
        rd_en_b = 1'b1;
        @(posedge clk);
        #1;
        rd_en_b = 1'b0;
        @(negedge clk);
        chk("t5_pp_count", count_b, 16);
      end
    join
    @(negedge clk);
    chk("t5_pp_ov", ov_b, 0);
    chk("t5_pp_head", data_b, 8'h01);
    for (int i = 1; i <= 16; i++) begin
      @(negedge clk);
      chk("t5_drain", data_b, i);
      pop(1);
    end
    @(negedge clk);
    chk("t5_empty", valid_b, 0);

    // short glitch is rejected (0xA5 still held)
    sync();
    rxd_a = 1'b0;
    repeat (50) @(posedge clk);
    #1;
    rxd_a = 1'b1;
    repeat (300) @(posedge clk);
    @(negedge clk);
    chk("t6_glitch_c", count_a, 1);
    chk("t6_glitch_f", {ov_a, fe_a, pe_a}, 0);

    // reset during data bits
    sync();
    hold_bit(0, 1'b0);
    hold_bit(0, 1'b0);
    hold_bit(0, 1'b0);
    hold_bit(0, 1'b1);
    rst_a = 1'b1;
    rxd_a = 1'b1;
    @(negedge clk);
    chk("t6_rst_v", valid_a, 0);
    chk("t6_rst_c", count_a, 0);
    chk("t6_rst_d", data_a, 0);
    sync();
    rst_a = 1'b0;
    repeat (CA) @(posedge clk);
    #1;
    send(0, 8'h3C, 0, 1'b1);
    @(negedge clk);
    chk("t6_count", count_a, 1);
    chk("t6_data", data_a, 8'h3C);
    chk("t6_flags", {ov_a, fe_a, pe_a}, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
